// File: rtl/scan_decoder_pkg.sv
// Shared types and constants for the scan_decoder block: FSM state encoding
// and the meaning of the mode input.
package scan_decoder_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIRECT = 2'd1,
      SCAN   = 2'd2
   } state_e;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

endpackage : scan_decoder_pkg

// File: rtl/scan_decoder_if.sv
// Select-code handshake bundle: the producer presents sel with in_valid,
// and the decoder answers with in_ready.
interface scan_decoder_if #(
   parameter int SEL_W = 2
);
   logic             in_valid;
   logic             in_ready;
   logic [SEL_W-1:0] sel;

   modport master (output in_valid, output sel, input in_ready);
   modport slave  (input in_valid, input sel, output in_ready);
endinterface : scan_decoder_if

// File: rtl/scan_decoder_onehot_dec.sv
// Parametrised combinational binary-to-one-hot decoder, SEL_W -> 2**SEL_W.
module onehot_dec #(
   parameter int SEL_W = 2
) (
   input  logic [SEL_W-1:0]    code_i,
   output logic [2**SEL_W-1:0] onehot_o
);

   // Exactly one bit set, at the position named by code_i.
   always_comb begin
      onehot_o         = '0;
      onehot_o[code_i] = 1'b1;
   end

endmodule : onehot_dec

// File: rtl/scan_decoder.sv
// Registered one-hot decoder with a handshake-driven direct mode and an
// autonomous scan mode that dwells DWELL cycles on each output line.
module scan_decoder
   import scan_decoder_pkg::*;
#(
   parameter int SEL_W = 2,
   parameter int DWELL = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic                mode,
   scan_decoder_if.slave       bus,
   output logic [2**SEL_W-1:0] out,
   output logic [SEL_W-1:0]    idx,
   output logic                wrap
);

   localparam int OUT_W = 2**SEL_W;
   localparam int CNT_W = $clog2(DWELL + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
   localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(OUT_W - 1);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [SEL_W-1:0] idx_q;
   logic [OUT_W-1:0] out_q;
   logic             wrap_q;

   logic             accept_s;
   logic             step_s;
   logic [SEL_W-1:0] scan_code_s;
   logic [OUT_W-1:0] sel_onehot_s;
   logic [OUT_W-1:0] scan_onehot_s;

   assign bus.in_ready = en & (mode == MODE_DIRECT);
   assign accept_s     = bus.in_valid & bus.in_ready;
   assign step_s       = (cnt_q == CNT_LAST);

   // Outside SCAN the scan path decodes line 0, the line a fresh scan starts on.
   assign scan_code_s = (state_q != SCAN) ? {SEL_W{1'b0}} :
                        step_s            ? idx_q + 1'b1  : idx_q;

   onehot_dec #(.SEL_W(SEL_W)) u_sel_dec (
      .code_i   (bus.sel),
      .onehot_o (sel_onehot_s)
   );

   onehot_dec #(.SEL_W(SEL_W)) u_scan_dec (
      .code_i   (scan_code_s),
      .onehot_o (scan_onehot_s)
   );

   // Mode FSM together with the dwell counter and the registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         out_q   <= '0;
         wrap_q  <= 1'b0;
      end else if (!en) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         out_q   <= '0;
         wrap_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DIRECT: begin
               wrap_q <= 1'b0;
               cnt_q  <= '0;
               if (mode == MODE_SCAN) begin
                  state_q <= SCAN;
                  idx_q   <= '0;
                  out_q   <= scan_onehot_s;
               end else if (accept_s) begin
                  state_q <= DIRECT;
                  idx_q   <= bus.sel;
                  out_q   <= sel_onehot_s;
               end else begin
                  state_q <= state_q;
               end
            end
            SCAN: begin
               if (mode == MODE_DIRECT) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
                  idx_q   <= '0;
                  out_q   <= '0;
                  wrap_q  <= 1'b0;
               end else if (step_s) begin
                  cnt_q  <= '0;
                  idx_q  <= scan_code_s;
                  out_q  <= scan_onehot_s;
                  wrap_q <= (idx_q == IDX_LAST);
               end else begin
                  cnt_q  <= cnt_q + 1'b1;
                  wrap_q <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
               idx_q   <= '0;
               out_q   <= '0;
               wrap_q  <= 1'b0;
            end
         endcase
      end
   end

   assign out  = out_q;
   assign idx  = idx_q;
   assign wrap = wrap_q;

endmodule : scan_decoder

// File: tb/tb_scan_decoder.sv
// Directed self-checking bench for scan_decoder: one instance with SEL_W=2,
// DWELL=3 and a second with SEL_W=3, DWELL=1.
module tb_scan_decoder;

   logic clk;
   logic rst_n;

   logic       en_a, mode_a;
   logic [3:0] out_a;
   logic [1:0] idx_a;
   logic       wrap_a;

   logic       en_b, mode_b;
   logic [7:0] out_b;
   logic [2:0] idx_b;
   logic       wrap_b;

   int checks;
   int errors;

   scan_decoder_if #(.SEL_W(2)) bus_a ();
   scan_decoder_if #(.SEL_W(3)) bus_b ();

   scan_decoder #(.SEL_W(2), .DWELL(3)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en_a),
      .mode  (mode_a),
      .bus   (bus_a),
      .out   (out_a),
      .idx   (idx_a),
      .wrap  (wrap_a)
   );

   scan_decoder #(.SEL_W(3), .DWELL(1)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en_b),
      .mode  (mode_b),
      .bus   (bus_b),
      .out   (out_b),
      .idx   (idx_b),
      .wrap  (wrap_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected out for 13 cycles of scan with DWELL=3 over 4 lines.
   logic [3:0] scan_tab [13];
   logic [1:0] scan_idx_tab [13];

   initial begin
      scan_tab     = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0010,
                       4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b1000, 4'b0001};
      scan_idx_tab = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1,
                       2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
      checks = 0;
      errors = 0;

      rst_n          = 1'b0;
      en_a           = 1'b0;
      mode_a         = 1'b0;
      bus_a.in_valid = 1'b0;
      bus_a.sel      = 2'd0;
      en_b           = 1'b0;
      mode_b         = 1'b0;
      bus_b.in_valid = 1'b0;
      bus_b.sel      = 3'd0;

      // Reset state, in_ready tracking en/mode while in reset.
      tick();
      tick();
      check_val("rst_out", {28'd0, out_a}, 32'h0);
      check_val("rst_idx", {30'd0, idx_a}, 32'h0);
      check_val("rst_wrap", {31'd0, wrap_a}, 32'h0);
      check_val("rst_rdy_en0", {31'd0, bus_a.in_ready}, 32'h0);
      en_a = 1'b1;
      #1;
      check_val("rst_rdy_en1", {31'd0, bus_a.in_ready}, 32'h1);
      tick();
      check_val("rst_hold_out", {28'd0, out_a}, 32'h0);
      #2 rst_n = 1'b1;

      // Single accept of sel=2, then hold for 10 cycles.
      tick();
      bus_a.sel      = 2'd2;
      bus_a.in_valid = 1'b1;
      tick();
      bus_a.in_valid = 1'b0;
      check_val("dir_out", {28'd0, out_a}, 32'h4);
      check_val("dir_idx", {30'd0, idx_a}, 32'h2);
      for (int i = 0; i < 10; i++) begin
         tick();
         check_val("dir_hold", {28'd0, out_a}, 32'h4);
      end
      check_val("dir_hold_idx", {30'd0, idx_a}, 32'h2);

      // Back-to-back accepts of every code.
      for (int s = 0; s < 4; s++) begin
         bus_a.sel      = 2'(s);
         bus_a.in_valid = 1'b1;
         #1;
         check_val("b2b_rdy", {31'd0, bus_a.in_ready}, 32'h1);
         tick();
         check_val("b2b_out", {28'd0, out_a}, 32'h1 << s);
         check_val("b2b_idx", {30'd0, idx_a}, s);
      end

      // en=0 with a pending handshake: ignored, block goes idle.
      bus_a.sel = 2'd1;
      en_a      = 1'b0;
      #1;
      check_val("en0_rdy", {31'd0, bus_a.in_ready}, 32'h0);
      tick();
      check_val("en0_out", {28'd0, out_a}, 32'h0);
      check_val("en0_idx", {30'd0, idx_a}, 32'h0);
      bus_a.in_valid = 1'b0;

      // Scan from IDLE for 13 cycles.
      en_a   = 1'b1;
      mode_a = 1'b1;
      for (int i = 0; i < 13; i++) begin
         tick();
         check_val("scan_out", {28'd0, out_a}, {28'd0, scan_tab[i]});
         check_val("scan_idx", {30'd0, idx_a}, {30'd0, scan_idx_tab[i]});
         check_val("scan_wrap", {31'd0, wrap_a}, (i == 12) ? 32'h1 : 32'h0);
      end

      // in_valid during scan has no effect.
      bus_a.sel      = 2'd3;
      bus_a.in_valid = 1'b1;
      #1;
      check_val("scan_rdy", {31'd0, bus_a.in_ready}, 32'h0);
      tick();
      check_val("scan_iv_out0", {28'd0, out_a}, 32'h1);
      tick();
      check_val("scan_iv_out1", {28'd0, out_a}, 32'h1);
      tick();
      check_val("scan_iv_out2", {28'd0, out_a}, 32'h2);
      check_val("scan_iv_wrap", {31'd0, wrap_a}, 32'h0);
      bus_a.in_valid = 1'b0;
      mode_a         = 1'b0;
      tick();
      check_val("scan_exit_out", {28'd0, out_a}, 32'h0);
      check_val("scan_exit_idx", {30'd0, idx_a}, 32'h0);

      // Asynchronous reset mid-scan at idx=2.
      mode_a = 1'b1;
      tick();
      check_val("rs_entry", {28'd0, out_a}, 32'h1);
      for (int i = 0; i < 6; i++) tick();
      check_val("rs_pre_idx", {30'd0, idx_a}, 32'h2);
      check_val("rs_pre_out", {28'd0, out_a}, 32'h4);
      #2 rst_n = 1'b0;
      #1;
      check_val("rs_async_out", {28'd0, out_a}, 32'h0);
      check_val("rs_async_idx", {30'd0, idx_a}, 32'h0);
      #1 rst_n = 1'b1;
      tick();
      check_val("rs_restart_out", {28'd0, out_a}, 32'h1);
      check_val("rs_restart_wrap", {31'd0, wrap_a}, 32'h0);
      tick();
      tick();
      tick();
      check_val("rs_step_out", {28'd0, out_a}, 32'h2);
      en_a = 1'b0;

      // SEL_W=3, DWELL=1: one line per cycle, wrap every 8th cycle.
      en_b   = 1'b1;
      mode_b = 1'b1;
      for (int i = 0; i < 17; i++) begin
         tick();
         check_val("w8_out", {24'd0, out_b}, 32'h1 << (i % 8));
         check_val("w8_idx", {29'd0, idx_b}, i % 8);
         check_val("w8_wrap", {31'd0, wrap_b}, ((i % 8 == 0) && (i > 0)) ? 32'h1 : 32'h0);
      end
      mode_b = 1'b0;
      tick();
      check_val("w8_exit", {24'd0, out_b}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_scan_decoder
